// File: rtl/mem_prog_loader_pkg.sv
// Shared types and constants for the memory program loader.
package mem_prog_loader_pkg;

  localparam logic [7:0] HDR_END = 8'hFF;
  localparam int         LEN_W   = 16;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    LEN0,
    LEN1,
    DATA,
    CKSUM,
    DONE,
    ERR
  } state_e;

endpackage

// File: rtl/mem_prog_loader_word_packer.sv
// prog_word_packer: shifts received bytes LSB-first into a DATA_W word,
// tracks the byte index and emits a one-cycle word-ready pulse together
// with a held copy of the completed word.
module prog_word_packer #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              vld_i,
  input  logic [7:0]        byte_i,
  output logic              at_last_o,
  output logic [DATA_W-1:0] word_o,
  output logic              vld_o
);

  localparam int BPW   = DATA_W / 8;
  localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

  logic [IDX_W-1:0]  idx_p0;
  logic [DATA_W-1:0] shift_p0;
  logic [DATA_W-1:0] asm_w;
  logic [DATA_W-1:0] word_p1;
  logic              vld_p1;

  // Newest byte enters at the top so the first byte ends up in bits [7:0].
  generate
    if (DATA_W == 8) begin : g_single
      assign asm_w = byte_i;
    end else begin : g_multi
      assign asm_w = {byte_i, shift_p0[DATA_W-1:8]};
    end
  endgenerate

  assign at_last_o = (idx_p0 == IDX_W'(BPW - 1));

  // Stage p0 -> p1: byte accumulation, word capture and ready pulse
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_p0   <= '0;
      shift_p0 <= '0;
      word_p1  <= '0;
      vld_p1   <= 1'b0;
    end else begin
      vld_p1 <= vld_i && at_last_o;
      if (clr_i) begin
        idx_p0 <= '0;
      end else if (vld_i) begin
        shift_p0 <= asm_w;
        if (at_last_o) begin
          idx_p0  <= '0;
          word_p1 <= asm_w;
        end else begin
          idx_p0 <= idx_p0 + IDX_W'(1);
        end
      end
    end
  end

  assign word_o = word_p1;
  assign vld_o  = vld_p1;

endmodule

// File: rtl/mem_prog_loader.sv
// mem_prog_loader: receives a byte stream of sections (header, 16-bit
// little-endian word count, data) and writes the words into one of NUM_MEM
// memories while holding the core in reset.
// Optional feature: define MEM_PROG_LOADER_CKSUM_EN to require a modulo-256
// checksum byte after each section's data.
module mem_prog_loader
  import mem_prog_loader_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 12,
  parameter int NUM_MEM = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               prog_i,
  input  logic               rx_valid_i,
  input  logic [7:0]         rx_byte_i,
  output logic [NUM_MEM-1:0] we_o,
  output logic [ADDR_W-1:0]  addr_o,
  output logic [DATA_W-1:0]  wdata_o,
  output logic               core_rst_o,
  output logic               done_o,
  output logic               err_o
);

  state_e            state_q, state_d;
  logic [7:0]        sel_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  widx_q;
  logic [ADDR_W-1:0] addr_p1;
  logic              consume, clr, sel_we, len_lo_we, len_hi_we;
  logic              pk_at_last, pk_vld;
  logic [DATA_W-1:0] pk_word;
  logic [LEN_W-1:0]  len_full;
  logic              too_long;
  logic              last_word;
`ifdef MEM_PROG_LOADER_CKSUM_EN
  logic [7:0]        sum_q;
`endif

  assign len_full  = {rx_byte_i, len_q[7:0]};
  assign too_long  = 32'(len_full) > (32'd1 << ADDR_W);
  assign last_word = pk_at_last && (widx_q == len_q - LEN_W'(1));

  prog_word_packer #(.DATA_W(DATA_W)) u_packer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (clr),
    .vld_i     (consume),
    .byte_i    (rx_byte_i),
    .at_last_o (pk_at_last),
    .word_o    (pk_word),
    .vld_o     (pk_vld)
  );

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and per-byte control strobes; a dropped prog_i aborts first
  always_comb begin
    state_d   = state_q;
    consume   = 1'b0;
    clr       = 1'b0;
    sel_we    = 1'b0;
    len_lo_we = 1'b0;
    len_hi_we = 1'b0;
    case (state_q)
      IDLE: if (prog_i) state_d = HDR;
      HDR: begin
        if (!prog_i) state_d = ERR;
        else if (rx_valid_i) begin
          if (rx_byte_i == HDR_END) state_d = DONE;
          else if (32'(rx_byte_i) < 32'(NUM_MEM)) begin
            sel_we  = 1'b1;
            state_d = LEN0;
          end else state_d = ERR;
        end
      end
      LEN0: begin
        if (!prog_i) state_d = ERR;
        else if (rx_valid_i) begin
          len_lo_we = 1'b1;
          state_d   = LEN1;
        end
      end
      LEN1: begin
        if (!prog_i) state_d = ERR;
        else if (rx_valid_i) begin
          len_hi_we = 1'b1;
          clr       = 1'b1;
`ifdef MEM_PROG_LOADER_CKSUM_EN
          if (len_full == '0) state_d = CKSUM;
`else
          if (len_full == '0) state_d = HDR;
`endif
          else if (too_long)  state_d = ERR;
          else                state_d = DATA;
        end
      end
      DATA: begin
        if (!prog_i) state_d = ERR;
        else if (rx_valid_i) begin
          consume = 1'b1;
`ifdef MEM_PROG_LOADER_CKSUM_EN
          if (last_word) state_d = CKSUM;
`else
          if (last_word) state_d = HDR;
`endif
        end
      end
`ifdef MEM_PROG_LOADER_CKSUM_EN
      CKSUM: begin
        if (!prog_i) state_d = ERR;
        else if (rx_valid_i) state_d = (rx_byte_i == sum_q) ? HDR : ERR;
      end
`endif
      DONE, ERR: if (!prog_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Section bookkeeping: target select, word count, word index and address
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sel_q   <= '0;
      len_q   <= '0;
      widx_q  <= '0;
      addr_p1 <= '0;
    end else begin
      if (sel_we)    sel_q       <= rx_byte_i;
      if (len_lo_we) len_q[7:0]  <= rx_byte_i;
      if (len_hi_we) len_q[15:8] <= rx_byte_i;
      if (clr) widx_q <= '0;
      else if (consume && pk_at_last) begin
        addr_p1 <= ADDR_W'(widx_q);
        widx_q  <= widx_q + LEN_W'(1);
      end
    end
  end

`ifdef MEM_PROG_LOADER_CKSUM_EN
  // Running modulo-256 sum of the current section's data bytes
  always_ff @(posedge clk_i) begin
    if (rst_i)        sum_q <= '0;
    else if (clr)     sum_q <= '0;
    else if (consume) sum_q <= sum_q + rx_byte_i;
  end
`endif

  assign we_o       = pk_vld ? (NUM_MEM'(1) << sel_q) : '0;
  assign addr_o     = addr_p1;
  assign wdata_o    = pk_word;
  assign core_rst_o = !((state_q == IDLE) || (state_q == DONE));
  assign done_o     = (state_q == DONE);
  assign err_o      = (state_q == ERR);

endmodule

// File: doc/mem_prog_loader.md
MEM_PROG_LOADER -- requirements
Module: mem_prog_loader

Interface
REQ-001 SHALL have parameter DATA_W, default 32, memory word width in bits (a multiple of 8, at least 8).
REQ-002 SHALL have parameter ADDR_W, default 12, word-address width.
REQ-003 SHALL have parameter NUM_MEM, default 2, number of target memories (1..255).
REQ-004 SHALL have port clk_i  in  1  sole clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_i  in  1  reset, synchronous and active-high.
REQ-006 SHALL have port prog_i  in  1  programming-mode request, level.
REQ-007 SHALL have port rx_valid_i  in  1  one-cycle strobe marking rx_byte_i valid.
REQ-008 SHALL have port rx_byte_i  in  8  received byte.
REQ-009 SHALL have port we_o  out  NUM_MEM  one-hot write strobe, one bit per memory.
REQ-010 SHALL have port addr_o  out  ADDR_W  word address.
REQ-011 SHALL have port wdata_o  out  DATA_W  write data.
REQ-012 SHALL have port core_rst_o  out  1  holds the core in reset, active-high.
REQ-013 SHALL have port done_o  out  1  load completed.
REQ-014 SHALL have port err_o  out  1  load aborted.

Function
REQ-015 SHALL implement the states IDLE, HDR, LEN0, LEN1, DATA, CKSUM, DONE and ERR.
REQ-016 IDLE: if prog_i=1, SHALL move to HDR on the next edge.
REQ-017 HDR, on a byte: 0xFF -> DONE; a byte below NUM_MEM latches sel, then -> LEN0; any other byte -> ERR.
REQ-018 LEN0/LEN1 SHALL capture a 16-bit word count, little-endian; LEN1 SHALL clear the word address and byte index.
REQ-019 After LEN1: count=0 -> HDR (CKSUM if the checksum is enabled); count>2^ADDR_W -> ERR; otherwise -> DATA.
REQ-020 DATA SHALL assemble DATA_W/8 bytes LSB-first; bytes SHALL be consumed only when rx_valid_i=1.
REQ-021 On the last byte of a word, the next cycle SHALL pulse we_o[sel] for exactly 1 cycle, with addr_o = word index and wdata_o = the assembled word.
REQ-022 The word index SHALL start at 0 for each section and increment after each write.
REQ-023 After word count-1 is written, the FSM SHALL go to CKSUM if the checksum is enabled, else to HDR.
REQ-024 Outside a write pulse, we_o SHALL be 0; addr_o and wdata_o SHALL hold their last values.
REQ-025 core_rst_o SHALL be 1 in HDR, LEN0, LEN1, DATA, CKSUM and ERR, and 0 in IDLE and DONE.
REQ-026 done_o SHALL be 1 only in DONE; err_o SHALL be 1 only in ERR.
REQ-027 DONE and ERR SHALL return to IDLE when prog_i=0; bytes received in these states SHALL be ignored.
REQ-028 If prog_i falls in HDR, LEN0, LEN1, DATA or CKSUM -> ERR on the next edge; a partial word SHALL be discarded with no write.
REQ-029 If rx_valid_i arrives in the same cycle as a write pulse, the byte SHALL be accepted with no loss; the design sustains 1 byte per cycle.
REQ-030 Bytes received in IDLE SHALL be ignored.

Reset
REQ-031 With rst_i=1 at an edge: state=IDLE, we_o=0, addr_o=0, wdata_o=0, done_o=0, err_o=0, core_rst_o=0, and all counters, sel and the checksum cleared.
REQ-032 Reset SHALL take priority over every other event, including mid-word; no write SHALL occur in the reset cycle.

Configuration
REQ-033 With the macro MEM_PROG_LOADER_CKSUM_EN defined: after each section's data, one byte SHALL be expected equal to the 8-bit modulo-256 sum of that section's data bytes; match -> HDR, mismatch -> ERR; the sum SHALL clear at LEN1.
REQ-034 Without the macro: the CKSUM state, the adder and the sum register SHALL be absent, and the FSM SHALL go straight to HDR.

Structure
REQ-035 A shared package mem_prog_loader_pkg SHALL hold the state enum type, the HDR_END=8'hFF constant and the LEN_W=16 constant.
REQ-036 One sub-module, prog_word_packer (byte-to-word shift and assembly, byte index, word-ready pulse), SHALL be instantiated inside; the FSM SHALL stay in the top module.

Verification
REQ-037 Default parameters, prog_i=1, bytes 00 02 00 | 11 22 33 44 | 55 66 77 88 | [CKSUM 0x64 if enabled] | FF -> we_o=01 with addr 0 and data 0x44332211, then addr 1 and data 0x88776655; done_o=1 and core_rst_o=0.
REQ-038 Header 0x05 with NUM_MEM=2 -> err_o=1, core_rst_o=1, no write; prog_i=0 -> IDLE with err_o=0.
REQ-039 prog_i dropped after 2 data bytes -> ERR next cycle, no we_o pulse.
REQ-040 CKSUM_EN build, section 01 01 00 | AA BB CC DD with checksum 0x00 (correct is 0x0E) -> ERR after a single write of 0xDDCCBBAA to memory 1.
REQ-041 Back-to-back bytes every cycle, DATA_W=8, count 0x0003 -> three consecutive we_o pulses at addr 0, 1, 2 with no dropped byte.
REQ-042 rst_i asserted mid-word -> all outputs at reset values next cycle; a new load afterwards starts at addr 0.
